seq_restoring_divider: RTL

//  Iterative unsigned restoring divider, one quotient bit per clock.

---
 rtl/seq_restoring_divider.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned restoring divider, one quotient
// bit per clock. It produces q = x / y and r = x % y after WIDTH cycles.
// Operands are captured when a start is accepted. Results are held until the
// next completion.
//
// Optional macro: DIV_ZERO_CHECK_EN.
//   When it is defined, a zero divisor skips the iteration and completes at once.
//   When it is undefined, div_by_zero_o is tied low and a zero divisor runs the
//   full sequence, which gives q = all ones and r = x.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   start_i        request; accepted in IDLE or DONE
//   x_i, y_i       dividend / divisor, captured on accept
//   busy_o         high while iterating
//   done_o         one-cycle completion pulse
//   q_o, r_o       quotient / remainder, held after done
//   div_by_zero_o  zero-divisor flag, valid with done and held
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
`ifdef DIV_ZERO_CHECK_EN
    logic             dbz_q, dbz_d;
`endif

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   rem_n;
    logic [WIDTH-1:0] quo_n;
    logic             accept;

    // The remainder never exceeds WIDTH bits, so its MSB drops out of the shift.
    logic             unused_rem_msb;
    assign unused_rem_msb = rem_q[WIDTH];

    // One restoring step: shift {rem,quo} left, then try subtracting the divisor.
    always_comb begin
        rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        rem_n  = trial[WIDTH] ? rem_sh : trial;
        quo_n  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        accept = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        q_d     = q_q;
        r_d     = r_q;
`ifdef DIV_ZERO_CHECK_EN
        dbz_d   = dbz_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    rem_d   = '0;
                    quo_d   = x_i;
                    dvs_d   = y_i;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
`ifdef DIV_ZERO_CHECK_EN
                    dbz_d   = 1'b0;
                    // Zero divisor: report the natural all-ones result immediately.
                    if (y_i == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        q_d     = {WIDTH{1'b1}};
                        r_d     = x_i;
                        dbz_d   = 1'b1;
                    end
`endif
                end
            end
            S_RUN: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_d     = quo_n;
                    r_d     = rem_n[WIDTH-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
`ifdef DIV_ZERO_CHECK_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
`ifdef DIV_ZERO_CHECK_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign q_o    = q_q;
    assign r_o    = r_q;
`ifdef DIV_ZERO_CHECK_EN
    assign div_by_zero_o = dbz_q;
`else
    assign div_by_zero_o = 1'b0;
`endif

endmodule
